sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of independent switch channels.
REQ-002 Parameter STABLE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive clocks a synchronized input must differ from sw_clean before sw_clean updates; legal range >= 2.
REQ-003 Port clk  input  1: rising-edge clock for all state.
REQ-004 Port reset_n  input  1: reset, asynchronous, active-low.
REQ-005 Port sw_raw  input  WIDTH: raw, bouncing, asynchronous switch levels.
REQ-006 Port sw_clean  output  WIDTH: registered, debounced levels; drives the switch PIO in_port.
REQ-007 Port rise_pulse  output  WIDTH: one-clock registered strobe per bit on a sw_clean 0->1 transition.
REQ-008 Port fall_pulse  output  WIDTH: one-clock registered strobe per bit on a sw_clean 1->0 transition.
REQ-009 Port any_change  output  1: registered OR of all rise_pulse and fall_pulse bits in the same cycle.

Function
REQ-010 Each sw_raw bit passes through its own two-flop synchronizer (sync1, sync2) before any other logic; no logic reads sync1.
REQ-011 Each bit owns an up-counter of width clog2(STABLE_CYCLES), minimum 1 bit.
REQ-012 Per-bit, per-edge, sync2 == sw_clean: counter <= 0; sw_clean holds.
REQ-013 Per-bit, per-edge, sync2 != sw_clean and counter < STABLE_CYCLES-1: counter increments by 1.
REQ-014 Per-bit, per-edge, sync2 != sw_clean and counter == STABLE_CYCLES-1: sw_clean <= sync2, counter <= 0.
REQ-015 Counter never exceeds STABLE_CYCLES-1 and never wraps.
REQ-016 Latency: a sw_raw change held stable changes sw_clean on the (STABLE_CYCLES+2)th rising edge after the change is first sampled.
REQ-017 A mismatch lasting fewer than STABLE_CYCLES consecutive sync2 samples (a glitch or bounce) returns the counter to 0 and leaves sw_clean unchanged.
REQ-018 rise_pulse[i] is 1 exactly in the cycle following the edge at which sw_clean[i] goes 0->1, i.e. it is registered on that same edge; otherwise 0.
REQ-019 fall_pulse[i] follows the same rule as rise_pulse[i], for sw_clean[i] going 1->0.
REQ-020 Bits are fully independent: simultaneous transitions on several bits each produce their own pulse in the same cycle; any_change is a single 1-cycle pulse.
REQ-021 rise_pulse[i] and fall_pulse[i] are never both 1.
REQ-022 Minimum spacing between consecutive pulses on one bit is STABLE_CYCLES clocks.

Reset
REQ-023 reset_n low asynchronously clears sync1, sync2, all counters, sw_clean, rise_pulse, fall_pulse and any_change to 0.
REQ-024 Reset asserted mid-count discards the count. After release, a bit held at 1 produces sw_clean=1 and one rise_pulse after STABLE_CYCLES+2 edges.
REQ-025 Reset release is consumed synchronously by the integrating system; no internal reset synchronizer.

Verification (WIDTH=4, STABLE_CYCLES=4)
REQ-026 Reset, then sw_raw=4'b0000 held 20 clocks -> sw_clean=0, no pulses, any_change=0.
REQ-027 sw_raw[0] 0->1 held -> sw_clean[0]=1 on 6th edge; rise_pulse=4'b0001 and any_change=1 for exactly 1 cycle.
REQ-028 sw_raw[1] toggled 1,0,1,0 every 2 clocks, then held 1 -> no change during bouncing; sw_clean[1]=1 on 6th edge after final transition; single rise_pulse[1].
REQ-029 sw_raw 4'b1111 -> 4'b0000 with all bits stable -> fall_pulse=4'b1111 in one cycle, any_change single 1-cycle pulse.
REQ-030 sw_raw[2]=1 for 3 clocks only (glitch) -> sw_clean[2] stays 0, no pulse.
REQ-031 reset_n pulsed low at count 2 of a pending rise -> outputs 0 immediately; rise_pulse occurs 6 edges after release, not earlier.

Source files
------------

// File: rtl/sw_debounce.sv
`timescale 1ns/1ps
// Per-channel switch debouncer: two-flop synchronizer, saturating stability
// counter, registered debounced level and one-clock edge strobes.
module sw_debounce #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   localparam int unsigned CNT_W = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] expire;

   // A bit commits when it has mismatched for STABLE_CYCLES consecutive samples.
   always_comb begin
      expire = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         expire[i] = (sync2[i] != sw_clean[i]) && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         sw_clean <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] == sw_clean[i]) begin
               cnt[i] <= '0;
            end else if (expire[i]) begin
               cnt[i]      <= '0;
               sw_clean[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Strobes are registered on the same edge that updates sw_clean.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_pulse <= '0;
         fall_pulse <= '0;
         any_change <= 1'b0;
      end else begin
         rise_pulse <= expire & sync2;
         fall_pulse <= expire & ~sync2;
         any_change <= |expire;
      end
   end

endmodule
